// File: rtl/hub75_pkg.sv
// hub75_pkg: shared defaults, scan state encoding and BCM plane timing for HUB75 drivers
package hub75_pkg;
  localparam int WIDTH = 32;
  localparam int ROWS = 16;
  localparam int BITS = 4;
  localparam int BASE_SHOW = 64;
  typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, SHOW} state_t;
  // OE-low cycles for a plane: each plane doubles the weight of the previous one
  function automatic int unsigned show_len(input int unsigned plane, input int unsigned base = BASE_SHOW);
    return base << plane;
  endfunction
endpackage

// File: rtl/hub75_bcm_scheduler_plane_select.sv
// hub75_plane_select: picks bit[plane] out of each of the six colour fields of a framebuffer word
// fb_rdata : {r1,g1,b1,r2,g2,b2}, each BITS wide
// plane    : BCM plane being shifted
// pins     : {r1,g1,b1,r2,g2,b2} panel data bits
module hub75_plane_select #(
  parameter int BITS = hub75_pkg::BITS,
  parameter int PW = (BITS > 1) ? $clog2(BITS) : 1
) (
  input  logic [6*BITS-1:0] fb_rdata,
  input  logic [PW-1:0]     plane,
  output logic [5:0]        pins
);
  for (genvar f = 0; f < 6; f++) begin : g_f
    logic [BITS-1:0] fld;
    assign fld = fb_rdata[f*BITS +: BITS];
    assign pins[f] = fld[plane];
  end
endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: HUB75 1/16-scan scheduler driving BCM colour planes from a dual-half framebuffer
// clk, reset (async, active high), enable : run control
// fb_rd_en, fb_col, fb_row, fb_rdata      : framebuffer read port, data valid one cycle after fb_rd_en
// r1,g1,b1,r2,g2,b2, clk_out, lat, oe     : panel data, shift clock, latch, output enable (active low)
// row_addr                                : panel row address, only changes while oe is high
// frame_done                              : one-cycle pulse once the last plane of the last row has shown
module hub75_bcm_scheduler #(
  parameter int WIDTH = hub75_pkg::WIDTH,
  parameter int ROWS = hub75_pkg::ROWS,
  parameter int BITS = hub75_pkg::BITS,
  parameter int BASE_SHOW = hub75_pkg::BASE_SHOW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     fb_rd_en,
  output logic [$clog2(WIDTH)-1:0] fb_col,
  output logic [$clog2(ROWS)-1:0]  fb_row,
  input  logic [6*BITS-1:0]        fb_rdata,
  output logic                     r1,
  output logic                     g1,
  output logic                     b1,
  output logic                     r2,
  output logic                     g2,
  output logic                     b2,
  output logic [$clog2(ROWS)-1:0]  row_addr,
  output logic                     clk_out,
  output logic                     lat,
  output logic                     oe,
  output logic                     frame_done
);
  import hub75_pkg::*;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(ROWS);
  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int SW = $clog2(show_len(BITS - 1, BASE_SHOW));
  state_t state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic [SW-1:0] cnt;
  logic [5:0] sel, data_q, pins;
  logic last_col, last_plane, last_row, show_end;
  assign last_col = col == CW'(WIDTH - 1);
  assign last_plane = plane == PW'(BITS - 1);
  assign last_row = row == RW'(ROWS - 1);
  assign show_end = state == SHOW && cnt == '0;
  hub75_plane_select #(.BITS(BITS), .PW(PW)) u_sel (
    .fb_rdata(fb_rdata),
    .plane(plane),
    .pins(sel)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      plane <= '0;
      cnt <= '0;
      data_q <= '0;
      row_addr <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      frame_done <= show_end && last_plane && last_row;
      if (state == SHIFT_LO) data_q <= sel;
      if (state == SHIFT_HI) col <= last_col ? '0 : col + 1'b1;
      if (state == BLANK) row_addr <= row;
      if (state == LATCH) cnt <= SW'(show_len(32'(plane), BASE_SHOW) - 1);
      if (state == SHOW) cnt <= cnt - 1'b1;
      if (show_end) begin
        plane <= last_plane ? '0 : plane + 1'b1;
        if (last_plane) row <= last_row ? '0 : row + 1'b1;
      end
    end
  end
  // Data pins follow the read word in SHIFT_LO and hold it through the SHIFT_HI rising clock
  always_comb begin
    nxt = state;
    fb_rd_en = 1'b0;
    fb_col = '0;
    clk_out = 1'b0;
    lat = 1'b0;
    oe = 1'b1;
    pins = '0;
    case (state)
      IDLE: nxt = enable ? PREFETCH : IDLE;
      PREFETCH: begin
        fb_rd_en = 1'b1;
        nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        pins = sel;
        nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        clk_out = 1'b1;
        pins = data_q;
        fb_rd_en = !last_col;
        fb_col = last_col ? '0 : col + 1'b1;
        nxt = last_col ? BLANK : SHIFT_LO;
      end
      BLANK: nxt = LATCH;
      LATCH: begin
        lat = 1'b1;
        nxt = SHOW;
      end
      SHOW: begin
        oe = 1'b0;
        nxt = cnt != '0 ? SHOW : enable ? PREFETCH : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign fb_row = fb_rd_en ? row : '0;
  assign {r1, g1, b1, r2, g2, b2} = pins;
endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// tb_hub75_bcm_scheduler: randomized-data directed bench checking scan, BCM timing, enable and reset behaviour
module tb_hub75_bcm_scheduler;
  localparam int WIDTH = 32;
  localparam int ROWS = 16;
  localparam int BITS = 4;
  localparam int BASE = 64;
  typedef struct {
    int row;
    int reads;
    bit cols_ok;
    int shifts;
    logic [WIDTH-1:0][5:0] pins;
    int lats;
    int ra;
    int low;
    longint start;
    longint stop;
  } rec_t;
  logic clk = 0, reset = 1, enable = 0;
  logic fb_rd_en, r1, g1, b1, r2, g2, b2, clk_out, lat, oe, frame_done;
  logic [4:0] fb_col;
  logic [3:0] fb_row, row_addr, prev_ra;
  logic [23:0] fb_rdata = '0;
  logic [23:0] mem [ROWS][WIDTH];
  rec_t recs [256];
  rec_t cur;
  int nrec = 0, fd_cnt = 0, viol = 0;
  bit act = 0, inlow = 0;
  longint cyc = 0, pf0 = -1, fd_cyc = 0;
  int total = 0, bad = 0, rd = 0;

  hub75_bcm_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_rd_en(fb_rd_en), .fb_col(fb_col), .fb_row(fb_row), .fb_rdata(fb_rdata),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .clk_out(clk_out), .lat(lat), .oe(oe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fb_rd_en) fb_rdata <= mem[fb_row][fb_col];

  // Segments the pin activity into one record per row-plane, from PREFETCH to the end of OE low
  always @(negedge clk) begin
    if (reset) begin
      act = 0;
      inlow = 0;
      nrec = 0;
      pf0 = -1;
      fd_cnt = 0;
    end else begin
      if (act && inlow && oe) begin
        cur.stop = cyc;
        if (nrec < 256) recs[nrec] = cur;
        nrec++;
        act = 0;
        inlow = 0;
      end
      if (!act && fb_rd_en && fb_col == 0) begin
        act = 1;
        cur.row = int'(fb_row);
        cur.reads = 0;
        cur.cols_ok = 1;
        cur.shifts = 0;
        cur.pins = '0;
        cur.lats = 0;
        cur.ra = -1;
        cur.low = 0;
        cur.start = cyc;
        if (pf0 < 0) pf0 = cyc;
      end
      if (act) begin
        if (fb_rd_en) begin
          if (int'(fb_col) != cur.reads || int'(fb_row) != cur.row) cur.cols_ok = 0;
          cur.reads++;
        end
        if (clk_out) begin
          if (cur.shifts < WIDTH) cur.pins[cur.shifts[4:0]] = {r1, g1, b1, r2, g2, b2};
          cur.shifts++;
        end
        if (lat) begin
          cur.lats++;
          cur.ra = int'(row_addr);
        end
        if (!oe) begin
          cur.low++;
          inlow = 1;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (!oe && row_addr != prev_ra) viol++;
      if (lat && !oe) viol++;
    end
    prev_ra = row_addr;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the bit of each colour field selected by the plane, packed r1 first
  function automatic logic [5:0] exp_pins(input logic [23:0] w, input int p);
    logic [5:0] e;
    for (int f = 0; f < 6; f++) e[5-f] = w[20 - 4*f + p];
    return e;
  endfunction

  task automatic rp(input int r, input int p);
    rec_t rec;
    int t = 0;
    bit ok = 1;
    while (nrec <= rd && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("rec_wait r%0d p%0d", r, p), longint'(nrec > rd), 1);
    if (nrec > rd) begin
      rec = recs[rd];
      rd++;
      for (int k = 0; k < WIDTH; k++)
        if (rec.pins[k] !== exp_pins(mem[r][k], p)) ok = 0;
      chk($sformatf("fb_row r%0d p%0d", r, p), rec.row, r);
      chk($sformatf("reads r%0d p%0d", r, p), rec.reads, WIDTH);
      chk($sformatf("col_seq r%0d p%0d", r, p), longint'(rec.cols_ok), 1);
      chk($sformatf("shifts r%0d p%0d", r, p), rec.shifts, WIDTH);
      chk($sformatf("pins r%0d p%0d", r, p), longint'(ok), 1);
      chk($sformatf("lat r%0d p%0d", r, p), rec.lats, 1);
      chk($sformatf("row_addr r%0d p%0d", r, p), rec.ra, r);
      chk($sformatf("oe_low r%0d p%0d", r, p), rec.low, BASE << p);
      chk($sformatf("cycles r%0d p%0d", r, p), rec.stop - rec.start, 67 + (BASE << p));
    end
  endtask

  initial begin
    int t;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < WIDTH; c++) mem[r][c] = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    chk("rst_oe", oe, 1);
    chk("rst_lat", lat, 0);
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_fb_col", fb_col, 0);
    chk("rst_fb_row", fb_row, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pins", {r1, g1, b1, r2, g2, b2}, 0);
    reset = 0;
    enable = 1;
    rp(0, 0);
    rp(0, 1);
    chk("no_early_frame_done", fd_cnt, 0);
    t = 0;
    while (oe && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_show", oe, 0);
    #2 reset = 1;
    #1;
    chk("async_rst_oe", oe, 1);
    chk("async_rst_lat", lat, 0);
    chk("async_rst_row_addr", row_addr, 0);
    repeat (2) @(negedge clk);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < WIDTH; c++) mem[r][c] = {c[3:0], 20'($urandom)};
    rd = 0;
    reset = 0;
    for (int i = 0; i < ROWS * BITS; i++) rp(i / BITS, i % BITS);
    repeat (2) @(negedge clk);
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_time", fd_cyc - pf0, 19648);
    for (int i = 0; i < 5 * BITS + 1; i++) rp(i / BITS, i % BITS);
    repeat (10 + $urandom_range(0, 20)) @(negedge clk);
    enable = 0;
    rp(5, 1);
    repeat ($urandom_range(20, 60)) @(negedge clk);
    chk("idle_oe", oe, 1);
    chk("idle_rd_en", fb_rd_en, 0);
    chk("idle_no_rec", nrec, rd);
    enable = 1;
    rp(5, 2);
    rp(5, 3);
    rp(6, 0);
    chk("frame_done_final", fd_cnt, 1);
    chk("oe_guard", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
- Scan scheduler for a 32x32 HUB75 panel (1/16 scan, two row halves).
- Sequences framebuffer reads, column shifting, latch and OE so each panel row shows BITS-deep colour by binary-code modulation (BCM).
- Sits between a dual-half RGB framebuffer (read port, fixed 1-cycle latency) and the panel pins.
- Replaces the single-bit scan FSM embedded in the sprite/logo display blocks.

Parameters:
- WIDTH, 32, columns per row.
- ROWS, 16, row addresses per half (scan depth).
- BITS, 4, colour bits per channel (number of BCM planes).
- BASE_SHOW, 64, OE-low cycles for plane 0; plane p shows BASE_SHOW<<p.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run scan when high.
- fb_rd_en  out  1  framebuffer read strobe.
- fb_col  out  5  read column.
- fb_row  out  4  read row (0..ROWS-1; applies to both halves).
- fb_rdata  in  6*BITS  {r1,g1,b1,r2,g2,b2}, each BITS wide, MSB first; valid the cycle after fb_rd_en.
- r1,g1,b1,r2,g2,b2  out  1 each  panel data.
- row_addr  out  4  panel row address.
- clk_out  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe  out  1  panel output enable, active low.
- frame_done  out  1  one-cycle pulse after the last plane of row ROWS-1.

Behaviour:
- Reset values:
  - oe=1; all other outputs 0 (including row_addr, fb_col, fb_row).
  - Internal row=0, plane=0, col=0; state IDLE.
- IDLE:
  - Outputs quiescent, oe=1.
  - enable=1 -> PREFETCH with row=0, plane=0.
- PREFETCH (1 cycle):
  - fb_rd_en=1, fb_col=0, fb_row=row.
  - -> SHIFT_LO.
- SHIFT_LO (1 cycle):
  - clk_out=0, oe=1.
  - Each colour pin = bit[plane] of its BITS field of fb_rdata.
  - -> SHIFT_HI.
- SHIFT_HI (1 cycle):
  - clk_out=1.
  - If col<WIDTH-1: fb_rd_en=1, fb_col=col+1, col++, -> SHIFT_LO.
  - Else: col=0, -> BLANK.
  - Data pins hold their value across SHIFT_HI.
- BLANK (1 cycle):
  - clk_out=0, oe=1.
  - row_addr<=row; row_addr only changes while oe=1.
  - -> LATCH.
- LATCH (1 cycle):
  - lat=1, oe=1.
  - Load show counter with (BASE_SHOW<<plane)-1.
  - -> SHOW.
- SHOW:
  - lat=0, oe=0; counter decrements.
  - Length is exactly BASE_SHOW<<plane cycles of oe=0.
  - On counter==0: oe<=1 next cycle, then advance.
- Advance:
  - plane<BITS-1 -> plane++.
  - Else plane=0 and row = (row==ROWS-1) ? 0 : row+1.
  - Row wrap pulses frame_done in the same cycle SHOW exits.
  - enable=1 -> PREFETCH; enable=0 -> IDLE.
- enable deassert mid-row: the current row/plane sequence always completes through SHOW. No truncated OE pulse, no partial latch.
- enable re-assert from IDLE: resumes at the stored row/plane (not row 0); only reset returns to row 0.
- Timing: cycles per row-plane = 1 + 2*WIDTH + 1 + 1 + (BASE_SHOW<<p) = 67 + (BASE_SHOW<<p) at defaults.
- Widths:
  - Show counter is wide enough for BASE_SHOW<<(BITS-1) (9 bits at defaults).
  - Column and row counters wrap without overflow at WIDTH-1 and ROWS-1.
- fb_rd_en asserts exactly WIDTH times per row-plane.
- Reset asserted mid-operation: all outputs return to reset values asynchronously (oe=1 immediately).

Decomposition:
- Package hub75_pkg holds:
  - WIDTH, ROWS, BITS defaults.
  - State encoding: IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, SHOW.
  - Function show_len(plane) = BASE_SHOW<<plane.
- One sub-module, hub75_plane_select: combinational, fb_rdata + plane -> six pin bits. Shared with later panel drivers.

Test Plan:
- Reset, then enable=1 with fb_rdata=all ones:
  - PREFETCH, then 32 clk_out rising edges with all colour pins 1.
  - lat high for 1 cycle; oe low for exactly 64 cycles.
  - Next plane's oe low for exactly 128 cycles.
- Framebuffer model returning r1 field = col[3:0]:
  - For plane 2, the shifted r1 sequence equals bit 2 of col.
  - fb_col runs 0..31 exactly once per row-plane.
- Full frame:
  - frame_done pulses once after 16 rows x 4 planes = 16*(4*67+960) = 19648 cycles from the first PREFETCH.
  - row_addr then wraps to 0.
- Deassert enable during SHIFT of row 5 plane 1:
  - Row 5 plane 1 completes with a full 128-cycle oe low, then IDLE with oe=1.
  - Re-enable resumes at row 5 plane 2.
- Reset asserted during SHOW:
  - oe=1 and lat=0 without waiting for a clock edge.
  - After release and enable=1, first fb_row=0.
- Checker across all tests: row_addr never changes while oe=0, and lat never asserts while oe=0.
